// File: rtl/pulse_sched_pkg.sv
// Shared types and constants for the pulse scheduler: state encoding, enable bit
// positions, default widths and the time-of-day record compared against the RTC.
package pulse_sched_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned PCNT_W_DEF = 16;
  localparam int unsigned ENA_BIT    = 0;
  localparam int unsigned IMM_BIT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } tod_t;

endpackage

// File: rtl/pulse_scheduler_if.sv
// Bus between the register bank / RTC timebase and the pulse scheduler, plus its outputs.
interface pulse_scheduler_if import pulse_sched_pkg::*; #(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) ();

  logic              i_us_tick;
  logic              i_sec_tick;
  logic [15:0]       i_rtc_year;
  logic [7:0]        i_rtc_month;
  logic [7:0]        i_rtc_day;
  logic [7:0]        i_rtc_hour;
  logic [7:0]        i_rtc_minutes;
  logic [7:0]        i_rtc_seconds;
  logic [7:0]        i_pulse_enable;
  logic [15:0]       i_usr_year;
  logic [7:0]        i_usr_month;
  logic [7:0]        i_usr_day;
  logic [7:0]        i_usr_hour;
  logic [7:0]        i_usr_minutes;
  logic [7:0]        i_usr_seconds;
  logic [CNT_W-1:0]  i_width_high;
  logic [CNT_W-1:0]  i_width_period;
  logic              o_pulse;
  logic [1:0]        o_state;
  logic              o_cfg_err;
  logic [PCNT_W-1:0] o_pulse_count;

  modport master (
    output i_us_tick, i_sec_tick,
    output i_rtc_year, i_rtc_month, i_rtc_day, i_rtc_hour, i_rtc_minutes, i_rtc_seconds,
    output i_pulse_enable,
    output i_usr_year, i_usr_month, i_usr_day, i_usr_hour, i_usr_minutes, i_usr_seconds,
    output i_width_high, i_width_period,
    input  o_pulse, o_state, o_cfg_err, o_pulse_count
  );

  modport slave (
    input  i_us_tick, i_sec_tick,
    input  i_rtc_year, i_rtc_month, i_rtc_day, i_rtc_hour, i_rtc_minutes, i_rtc_seconds,
    input  i_pulse_enable,
    input  i_usr_year, i_usr_month, i_usr_day, i_usr_hour, i_usr_minutes, i_usr_seconds,
    input  i_width_high, i_width_period,
    output o_pulse, o_state, o_cfg_err, o_pulse_count
  );

endinterface

// File: rtl/pulse_time_match.sv
// Start-time match: IMM forces a match, otherwise all six RTC fields must equal the user start time.
module pulse_time_match import pulse_sched_pkg::*; (
  input  logic imm,
  input  tod_t rtc,
  input  tod_t usr,
  output logic match_c
);

  assign match_c = imm || (rtc == usr);

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse train scheduler: arms on ENA, waits for the start second, then emits WIDTH_HIGH/PERIOD us pulses.
// Optional emitted-pulse counter enabled by defining PULSE_COUNT_EN.
module pulse_scheduler import pulse_sched_pkg::*; #(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pulse_scheduler_if.slave  bus
);

  state_e           state_q, state_nxt;
  logic             pulse_q, pulse_nxt;
  logic             cfg_err_q, cfg_err_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] sh_w_q, sh_w_nxt;
  logic [CNT_W-1:0] sh_p_q, sh_p_nxt;
  logic             pulse_start_c;
  logic             cnt_clr_c;
  logic             match_c;
  logic             ena, imm, cfg_valid_c;
  tod_t             rtc_tod, usr_tod;
  logic             unused_en_bits;

  assign ena            = bus.i_pulse_enable[ENA_BIT];
  assign imm            = bus.i_pulse_enable[IMM_BIT];
  assign unused_en_bits = ^bus.i_pulse_enable[7:2];
  assign cfg_valid_c    = (bus.i_width_high != '0) && (bus.i_width_period > bus.i_width_high);

  assign rtc_tod = {bus.i_rtc_year, bus.i_rtc_month, bus.i_rtc_day,
                    bus.i_rtc_hour, bus.i_rtc_minutes, bus.i_rtc_seconds};
  assign usr_tod = {bus.i_usr_year, bus.i_usr_month, bus.i_usr_day,
                    bus.i_usr_hour, bus.i_usr_minutes, bus.i_usr_seconds};

  pulse_time_match u_match (
    .imm     (imm),
    .rtc     (rtc_tod),
    .usr     (usr_tod),
    .match_c (match_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pulse_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      sh_w_q    <= '0;
      sh_p_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      pulse_q   <= pulse_nxt;
      cfg_err_q <= cfg_err_nxt;
      cnt_q     <= cnt_nxt;
      sh_w_q    <= sh_w_nxt;
      sh_p_q    <= sh_p_nxt;
    end
  end

  // Disable overrides everything, including a coincident period boundary.
  always_comb begin
    state_nxt     = state_q;
    pulse_nxt     = pulse_q;
    cfg_err_nxt   = cfg_err_q;
    cnt_nxt       = cnt_q;
    sh_w_nxt      = sh_w_q;
    sh_p_nxt      = sh_p_q;
    pulse_start_c = 1'b0;
    cnt_clr_c     = 1'b0;
    if (!ena) begin
      state_nxt   = ST_IDLE;
      pulse_nxt   = 1'b0;
      cfg_err_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid_c) begin
            state_nxt   = ST_WAIT;
            sh_w_nxt    = bus.i_width_high;
            sh_p_nxt    = bus.i_width_period;
            cnt_nxt     = '0;
            cfg_err_nxt = 1'b0;
            cnt_clr_c   = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.i_sec_tick && match_c) begin
            state_nxt     = ST_HIGH;
            cnt_nxt       = '0;
            pulse_nxt     = 1'b1;
            pulse_start_c = 1'b1;
          end
        end
        ST_HIGH: begin
          if (bus.i_us_tick) begin
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == sh_w_q - CNT_W'(1)) begin
              state_nxt = ST_LOW;
              pulse_nxt = 1'b0;
            end
          end
        end
        ST_LOW: begin
          if (bus.i_us_tick) begin
            if (cnt_q == sh_p_q - CNT_W'(1)) begin
              state_nxt     = ST_HIGH;
              cnt_nxt       = '0;
              pulse_nxt     = 1'b1;
              pulse_start_c = 1'b1;
              if (cfg_valid_c) begin
                sh_w_nxt = bus.i_width_high;
                sh_p_nxt = bus.i_width_period;
              end
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.o_pulse   = pulse_q;
  assign bus.o_state   = 2'(state_q);
  assign bus.o_cfg_err = cfg_err_q;

`ifdef PULSE_COUNT_EN
  logic [PCNT_W-1:0] pcnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              pcnt_q <= '0;
    else if (cnt_clr_c)     pcnt_q <= '0;
    else if (pulse_start_c) pcnt_q <= pcnt_q + PCNT_W'(1);
  end

  assign bus.o_pulse_count = pcnt_q;
`else
  logic unused_pcnt;

  assign unused_pcnt       = pulse_start_c | cnt_clr_c;
  assign bus.o_pulse_count = {PCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: config table, directed start/reconfig/disable/reset
// sequences, and randomized traffic checked against a phase-based reference model.
module tb_pulse_scheduler;

`ifdef PULSE_COUNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic i_clk;
  logic i_rst;
  int   errors;
  int   checks;

  pulse_scheduler_if #(.CNT_W(32), .PCNT_W(16)) bus ();

  pulse_scheduler #(.CNT_W(32), .PCNT_W(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: mode 0 idle, 1 waiting, 2 running; phase = us ticks into current period.
  int          m_mode;
  int unsigned m_w, m_p, m_phase;
  logic [15:0] m_pc;
  logic        m_err;

  typedef struct {
    logic [7:0]  en;
    logic [31:0] w;
    logic [31:0] p;
    logic [1:0]  st;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_w = 0; m_p = 0; m_phase = 0; m_pc = '0; m_err = 1'b0;
  endtask

  task automatic model_update();
    logic ena, imm, valid, tmatch;
    ena    = bus.i_pulse_enable[0];
    imm    = bus.i_pulse_enable[1];
    valid  = (bus.i_width_high != 0) && (bus.i_width_period > bus.i_width_high);
    tmatch = imm || ((bus.i_rtc_year == bus.i_usr_year) && (bus.i_rtc_month == bus.i_usr_month) &&
                     (bus.i_rtc_day == bus.i_usr_day) && (bus.i_rtc_hour == bus.i_usr_hour) &&
                     (bus.i_rtc_minutes == bus.i_usr_minutes) && (bus.i_rtc_seconds == bus.i_usr_seconds));
    if (!ena) begin
      m_mode = 0;
      m_err  = 1'b0;
    end else begin
      case (m_mode)
        0: if (valid) begin
             m_mode = 1; m_w = bus.i_width_high; m_p = bus.i_width_period;
             m_err = 1'b0; m_pc = '0;
           end else m_err = 1'b1;
        1: if (bus.i_sec_tick && tmatch) begin
             m_mode = 2; m_phase = 0; m_pc = m_pc + 16'd1;
           end
        default: if (bus.i_us_tick) begin
             m_phase = m_phase + 1;
             if (m_phase == m_p) begin
               m_phase = 0; m_pc = m_pc + 16'd1;
               if (valid) begin m_w = bus.i_width_high; m_p = bus.i_width_period; end
             end
           end
      endcase
    end
  endtask

  task automatic compare_model();
    logic       e_pulse;
    logic [1:0] e_state;
    e_pulse = (m_mode == 2) && (m_phase < m_w);
    e_state = (m_mode == 0) ? 2'd0 : (m_mode == 1) ? 2'd1 : (e_pulse ? 2'd2 : 2'd3);
    chk("model_pulse", 32'(bus.o_pulse), 32'(e_pulse));
    chk("model_state", 32'(bus.o_state), 32'(e_state));
    chk("model_cfg_err", 32'(bus.o_cfg_err), 32'(m_err));
    chk("model_pcount", 32'(bus.o_pulse_count), PC_EN ? 32'(m_pc) : 32'd0);
  endtask

  task automatic step();
    model_update();
    @(posedge i_clk);
    #1;
    compare_model();
  endtask

  task automatic us_cycle(input logic sec);
    bus.i_us_tick = 1'b1; bus.i_sec_tick = sec;
    step();
    bus.i_us_tick = 1'b0; bus.i_sec_tick = 1'b0;
    step();
  endtask

  // Counts us ticks while o_pulse stays at 'level'; bounded so a stuck output cannot hang.
  task automatic run_len(input logic level, input int exp, input string name);
    int n;
    n = 0;
    while (bus.o_pulse === level && n < 200) begin
      us_cycle(1'b0);
      n++;
    end
    chk(name, 32'(n), 32'(exp));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    i_rst = 1'b1;
    bus.i_us_tick = 1'b0;  bus.i_sec_tick = 1'b0;
    bus.i_rtc_year = 16'd2024; bus.i_rtc_month = 8'd5; bus.i_rtc_day = 8'd1;
    bus.i_rtc_hour = 8'd12; bus.i_rtc_minutes = 8'd0; bus.i_rtc_seconds = 8'd3;
    bus.i_usr_year = 16'd2024; bus.i_usr_month = 8'd5; bus.i_usr_day = 8'd1;
    bus.i_usr_hour = 8'd12; bus.i_usr_minutes = 8'd0; bus.i_usr_seconds = 8'd5;
    bus.i_pulse_enable = 8'h00;
    bus.i_width_high = 32'd3; bus.i_width_period = 32'd10;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_pulse", 32'(bus.o_pulse), 32'd0);
    chk("reset_state", 32'(bus.o_state), 32'd0);
    chk("reset_cfg_err", 32'(bus.o_cfg_err), 32'd0);
    chk("reset_pcount", 32'(bus.o_pulse_count), 32'd0);
    i_rst = 1'b0;

    // Configuration acceptance table, applied from IDLE.
    vecs[0] = '{8'h01, 32'd0,  32'd10, 2'd0, 1'b1};
    vecs[1] = '{8'h01, 32'd10, 32'd10, 2'd0, 1'b1};
    vecs[2] = '{8'h01, 32'd5,  32'd4,  2'd0, 1'b1};
    vecs[3] = '{8'h00, 32'd10, 32'd10, 2'd0, 1'b0};
    vecs[4] = '{8'h01, 32'd10, 32'd10, 2'd0, 1'b1};
    vecs[5] = '{8'h01, 32'd10, 32'd20, 2'd1, 1'b0};
    vecs[6] = '{8'hFD, 32'd1,  32'd2,  2'd1, 1'b0};
    vecs[7] = '{8'h02, 32'd3,  32'd10, 2'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (bus.o_state != 2'd0) begin
        bus.i_pulse_enable = 8'h00;
        step();
      end
      bus.i_pulse_enable = vecs[i].en;
      bus.i_width_high   = vecs[i].w;
      bus.i_width_period = vecs[i].p;
      step();
      chk($sformatf("cfg_vec%0d_state", i), 32'(bus.o_state), 32'(vecs[i].st));
      chk($sformatf("cfg_vec%0d_err", i), 32'(bus.o_cfg_err), 32'(vecs[i].err));
    end

    // Timed start at 2024-05-01 12:00:05, width 3 / period 10.
    bus.i_pulse_enable = 8'h00; step();
    bus.i_width_high = 32'd3; bus.i_width_period = 32'd10;
    bus.i_pulse_enable = 8'h01; step();
    for (int s = 3; s < 5; s++) begin
      bus.i_rtc_seconds = 8'(s);
      us_cycle(1'b1);
      us_cycle(1'b0);
      chk("timed_not_yet", 32'(bus.o_pulse), 32'd0);
    end
    bus.i_rtc_seconds = 8'd5;
    bus.i_us_tick = 1'b1; bus.i_sec_tick = 1'b1;
    step();
    chk("timed_start_pulse", 32'(bus.o_pulse), 32'd1);
    chk("timed_start_state", 32'(bus.o_state), 32'd2);
    bus.i_us_tick = 1'b0; bus.i_sec_tick = 1'b0;
    step();
    run_len(1'b1, 3, "timed_high1");
    run_len(1'b0, 7, "timed_low1");
    run_len(1'b1, 3, "timed_high2");
    run_len(1'b0, 7, "timed_low2");
    chk("timed_pcount", 32'(bus.o_pulse_count), PC_EN ? 32'd3 : 32'd0);

    // Live reconfiguration mid-period, then an invalid update that must be ignored.
    us_cycle(1'b0);
    bus.i_width_high = 32'd5; bus.i_width_period = 32'd20;
    run_len(1'b1, 2,  "reconf_cur_high");
    run_len(1'b0, 7,  "reconf_cur_low");
    run_len(1'b1, 5,  "reconf_new_high");
    run_len(1'b0, 15, "reconf_new_low");
    bus.i_width_period = 32'd4;
    run_len(1'b1, 5,  "reconf_bad_high1");
    run_len(1'b0, 15, "reconf_bad_low1");
    run_len(1'b1, 5,  "reconf_kept_high");
    run_len(1'b0, 15, "reconf_kept_low");

    // Disable during HIGH at count 1, then re-arm without a match.
    us_cycle(1'b0);
    bus.i_pulse_enable = 8'h00;
    step();
    chk("disable_pulse", 32'(bus.o_pulse), 32'd0);
    chk("disable_state", 32'(bus.o_state), 32'd0);
    bus.i_width_high = 32'd4; bus.i_width_period = 32'd9;
    bus.i_rtc_seconds = 8'd10;
    bus.i_pulse_enable = 8'h01;
    step();
    chk("rearm_state", 32'(bus.o_state), 32'd1);
    for (int k = 0; k < 3; k++) us_cycle(1'b0);
    chk("rearm_no_pulse", 32'(bus.o_pulse), 32'd0);
    chk("rearm_wait", 32'(bus.o_state), 32'd1);

    // IMM start with non-matching start time.
    bus.i_pulse_enable = 8'h03;
    us_cycle(1'b1);
    chk("imm_start", 32'(bus.o_pulse), 32'd1);
    run_len(1'b1, 4, "imm_high");
    run_len(1'b0, 5, "imm_low");
    chk("imm_pcount", 32'(bus.o_pulse_count), PC_EN ? 32'd2 : 32'd0);

    // Asynchronous reset while the pulse is high.
    chk("pre_reset_pulse", 32'(bus.o_pulse), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("async_rst_pulse", 32'(bus.o_pulse), 32'd0);
    chk("async_rst_state", 32'(bus.o_state), 32'd0);
    chk("async_rst_pcount", 32'(bus.o_pulse_count), 32'd0);
    model_reset();
    #2;
    i_rst = 1'b0;

    // Randomized traffic against the reference model.
    bus.i_usr_seconds = 8'd2;
    for (int it = 0; it < 3000; it++) begin
      logic [7:0] en;
      en = bus.i_pulse_enable;
      if ($urandom_range(0, 39) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 49) == 0) en[1] = ~en[1];
      en[7:2] = 6'($urandom);
      bus.i_pulse_enable = en;
      if ($urandom_range(0, 24) == 0) begin
        bus.i_width_high   = 32'($urandom_range(0, 6));
        bus.i_width_period = 32'($urandom_range(0, 12));
      end
      bus.i_us_tick  = 1'($urandom_range(0, 1));
      bus.i_sec_tick = bus.i_us_tick && ($urandom_range(0, 5) == 0);
      if (bus.i_sec_tick) begin
        bus.i_rtc_seconds = 8'($urandom_range(0, 3));
        bus.i_rtc_minutes = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
- Sequences the pulse output from the pulse-generator configuration register bank and the RTC time-of-day.
- Arms when enabled and waits for the user start time.
- Then emits a periodic pulse train: high for WIDTH_HIGH microseconds in every PERIOD microseconds.
- Sits between the register bank outputs, the RTC/timebase (second and microsecond strobes) and the output pin driver.

Parameters:
- CNT_W, 32, width of width/period values and the microsecond counter.
- PCNT_W, 16, width of the emitted-pulse counter (used only with PULSE_COUNT_EN).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_us_tick  in  1  one-cycle strobe, once per microsecond.
- i_sec_tick  in  1  one-cycle strobe at each second boundary; always coincident with an i_us_tick.
- i_rtc_year  in  16  current year.
- i_rtc_month, i_rtc_day, i_rtc_hour, i_rtc_minutes, i_rtc_seconds  in  8 each  current time.
- i_pulse_enable  in  8  bit0 ENA (run), bit1 IMM (start at next second, ignore start time); bits 7:2 ignored.
- i_usr_year  in  16  start year ({year_h, year_l}).
- i_usr_month, i_usr_day, i_usr_hour, i_usr_minutes, i_usr_seconds  in  8 each  start time.
- i_width_high  in  CNT_W  high time in us ({3,2,1,0}).
- i_width_period  in  CNT_W  period in us ({3,2,1,0}).
- o_pulse  out  1  registered pulse output.
- o_state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 HIGH, 3 LOW.
- o_cfg_err  out  1  ENA set with invalid configuration.
- o_pulse_count  out  PCNT_W  pulses emitted.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_pulse=0; o_cfg_err=0; o_pulse_count=0; us counter=0; shadow width/period=0.
- Config valid = (width_high != 0) && (width_period > width_high).
- All outputs are registered.

FSM:
- IDLE:
  - ENA=1 and config valid -> WAIT next clock; load shadow width/period from inputs; o_cfg_err=0.
  - ENA=1 and config invalid -> stay IDLE; o_cfg_err=1.
  - ENA=0 -> o_cfg_err=0.
- WAIT:
  - On i_sec_tick with match -> HIGH next clock.
  - Match = IMM=1, or all six RTC fields equal the corresponding usr fields in that cycle.
  - Counter cleared to 0; o_pulse=1 from the clock after the matching strobe.
  - Start time already past: stays in WAIT indefinitely; no catch-up.
- HIGH:
  - Each i_us_tick increments the counter, except the us_tick coincident with the starting sec_tick.
  - On the tick where counter == shadow_width-1 -> LOW; counter+1; o_pulse=0 next clock.
- LOW:
  - Each i_us_tick increments the counter.
  - On the tick where counter == shadow_period-1 -> HIGH; counter=0; reload shadows from inputs if the new config is valid, else keep the old shadows.
- Any state: ENA=0 -> IDLE on the next clock; o_pulse=0 immediately at that edge. A pulse in progress is truncated.
- Width/period changes apply only at a period boundary; a running train is never distorted mid-period.
- Counter never wraps in normal operation (bounded by period-1 < 2^CNT_W).
- Simultaneous ENA clear and boundary tick: ENA clear wins.
- Reset mid-pulse: o_pulse drops asynchronously.

Optional Feature:
- Macro PULSE_COUNT_EN.
- Defined: o_pulse_count increments on every WAIT->HIGH and LOW->HIGH transition; wraps modulo 2^PCNT_W; cleared on IDLE->WAIT and on reset.
- Undefined: o_pulse_count tied to 0; no counter logic.

Decomposition:
- Package pulse_sched_pkg: state encoding constants (ST_IDLE/ST_WAIT/ST_HIGH/ST_LOW); enable bit positions (ENA_BIT=0, IMM_BIT=1); CNT_W default.
- One sub-module, pulse_time_match: combinational equality of the six RTC vs user fields, gated by IMM, producing the match flag. The FSM and counter stay in the top.

Test Plan:
- Reset mid-pulse: i_rst asserted while o_pulse=1 -> o_pulse=0 without a clock edge; o_state=0; o_pulse_count=0.
- Invalid config: width=10, period=10, ENA=1 -> o_cfg_err=1, o_state stays 0. Fix period=20 -> o_state=1 next clock, o_cfg_err=0.
- Timed start: usr time 2024-05-01 12:00:05, width=3, period=10, ENA=1; RTC reaches 12:00:05 with sec_tick -> o_pulse=1 one clock later. o_pulse high for 3 us ticks, low for 7, repeating. o_pulse_count=1,2,3... with PULSE_COUNT_EN.
- IMM start: ENA=0x03 with a non-matching start time -> pulse begins after the next sec_tick; widths as configured.
- Live reconfig: running width=3/period=10; write width=5/period=20 mid-period -> current period unchanged, next period 5 high / 15 low. Write period=4 (invalid vs width 5) -> old 5/20 retained.
- Disable: ENA cleared during HIGH at count 1 -> o_pulse=0 and o_state=0 next clock. Re-enable -> returns to WAIT; no pulse until the next match.
